// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multi-cycle CPU. It serves one read or write
// at a time. Each request takes a fixed number of cycles, and completion is
// reported with a one-cycle mem_ready pulse.
module multicycle_mem_responder #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        mem_ready
);

  localparam int ADDR_BITS = $clog2(MEM_DEPTH);
  localparam int CNT_BITS  = ($clog2(LATENCY) < 2) ? 2 : $clog2(LATENCY);
  // The IDLE cycle and the READY cycle are part of the latency. BUSY therefore
  // lasts LATENCY-2 cycles, and the counter counts down from LATENCY-3 to 0.
  localparam logic [CNT_BITS-1:0] CNT_START =
    (LATENCY > 2) ? CNT_BITS'(LATENCY - 3) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   op_read_q, op_read_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            dout_q, dout_d;
  logic                   ready_q, ready_d;

  logic [31:0]            mem_q [MEM_DEPTH];
  logic [ADDR_BITS-1:0]   addr_idx;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic                   load_dout;
  logic                   mem_we;
  logic                   unused_addr_bits;

  // The byte offset is dropped, and so are the upper bits, so indexing wraps
  // modulo the depth.
  assign addr_idx         = addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0]};

  assign dout      = dout_q;
  assign mem_ready = ready_q;

  // Compute the next state, request capture, and read/write strobes for the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_read_d = op_read_q;
    idx_d     = idx_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    load_dout = 1'b0;
    rd_idx    = idx_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          // When both request lines are high, the read wins.
          op_read_d = mem_read;
          idx_d     = addr_idx;
          data_d    = din;
          if (LATENCY == 2) begin
            // Go straight to READY. The index is not latched yet, so read the array with the live address.
            state_d   = READY;
            ready_d   = 1'b1;
            load_dout = mem_read;
            rd_idx    = addr_idx;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_START;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d   = READY;
          ready_d   = 1'b1;
          load_dout = op_read_q;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      READY: begin
        state_d = IDLE;
        mem_we  = ~op_read_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dout_d = load_dout ? mem_q[rd_idx] : dout_q;
  end

  // Register the control state and the output registers. Reset returns everything to IDLE with zeroed latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_read_q <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_read_q <= op_read_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
    end
  end

  // Commit a write on the edge that closes READY. If reset hits that edge, the write is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Self-checking bench for multicycle_mem_responder. Three instances (LATENCY
// 4, 2 and 7) are checked every cycle against a queue-based completion model.
module tb_multicycle_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        rdy  [3];

  int lat [3] = '{4, 2, 7};
  int dep [3] = '{16384, 64, 64};

  multicycle_mem_responder #(.MEM_DEPTH(16384), .LATENCY(4)) dut0 (
    .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(addr[0]), .din(din[0]), .dout(dout[0]), .mem_ready(rdy[0]));
  multicycle_mem_responder #(.MEM_DEPTH(64), .LATENCY(2)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(addr[1]), .din(din[1]), .dout(dout[1]), .mem_ready(rdy[1]));
  multicycle_mem_responder #(.MEM_DEPTH(64), .LATENCY(7)) dut2 (
    .clk(clk), .reset(rst[2]), .mem_read(rd[2]), .mem_write(wr[2]),
    .addr(addr[2]), .din(din[2]), .dout(dout[2]), .mem_ready(rdy[2]));

  typedef struct {
    int          k;
    int          cyc;
    bit          is_read;
    int          idx;
    logic [31:0] data;
  } req_t;

  req_t        pend [$];
  logic [31:0] mmem [int];
  logic [31:0] exp_dout [3];
  bit          dout_known [3];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Count cycles so that completions can be scheduled at absolute cycle numbers.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int memKey(input int k, input int idx);
    return k * 65536 + idx;
  endfunction

  task automatic modelReset(input int k);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].k == k) pend.delete(i);
    exp_dout[k]   = 32'h0;
    dout_known[k] = 1'b1;
  endtask

  // Every cycle, retire any request the model expects to complete now and compare mem_ready/dout.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_r;
        int key;
        exp_r = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (pend[i].k == k && pend[i].cyc == cyc) begin
            exp_r = 1'b1;
            key = memKey(k, pend[i].idx);
            if (pend[i].is_read) begin
              if (mmem.exists(key)) begin
                exp_dout[k]   = mmem[key];
                dout_known[k] = 1'b1;
              end else begin
                dout_known[k] = 1'b0;
              end
            end else begin
              mmem[key] = pend[i].data;
            end
            pend.delete(i);
          end else if (pend[i].k == k && pend[i].cyc < cyc) begin
            pend.delete(i);
          end
        end
        checkOutput($sformatf("mem_ready dut%0d cyc%0d", k, cyc), {31'b0, rdy[k]}, {31'b0, exp_r});
        if (dout_known[k])
          checkOutput($sformatf("dout dut%0d cyc%0d", k, cyc), dout[k], exp_dout[k]);
      end
    end
  end

  // Issue one request. Hold it until mem_ready (optionally scrambling the inputs in cycle 1), then drop it.
  task automatic applyStimulus(input int k, input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input bit chg,
                               output int rel, output int rabs, output logic [31:0] rdout);
    int          start;
    bit          got;
    int unsigned ai;
    req_t        e;
    @(posedge clk); #1;
    rd[k] = r; wr[k] = w; addr[k] = a; din[k] = d;
    start = cyc;
    ai = a;
    e.k = k; e.cyc = start + lat[k] - 1; e.is_read = r;
    e.idx = int'((ai >> 2) % dep[k]); e.data = d;
    pend.push_back(e);
    if (chg) begin
      @(posedge clk); #1;
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = $urandom; din[k] = $urandom;
    end
    got = 1'b0; rel = -1; rabs = -1; rdout = 32'h0;
    for (int n = 0; n < lat[k] + 4 && !got; n++) begin
      @(negedge clk);
      if (rdy[k]) begin
        got = 1'b1; rabs = cyc; rel = cyc - start; rdout = dout[k];
      end
    end
    if (!got) checkOutput($sformatf("ready timeout dut%0d", k), 32'd0, 32'd1);
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  // Start a write and assert reset in cycle 2 of the request. The write must never complete.
  task automatic resetMidWrite(input int k, input logic [31:0] a, input logic [31:0] d);
    int          ai;
    bit          seen;
    req_t        e;
    @(posedge clk); #1;
    wr[k] = 1'b1; addr[k] = a; din[k] = d;
    ai = int'(a);
    e.k = k; e.cyc = cyc + lat[k] - 1; e.is_read = 1'b0;
    e.idx = (ai >>> 2) % dep[k]; e.data = d;
    pend.push_back(e);
    repeat (2) begin @(posedge clk); #1; end
    rst[k] = 1'b1; wr[k] = 1'b0;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    modelReset(k);
    seen = 1'b0;
    repeat (lat[k] + 2) begin
      @(negedge clk);
      if (rdy[k]) seen = 1'b1;
    end
    checkOutput($sformatf("no ready after reset dut%0d", k), {31'b0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          rel, rabs, rabs2;
    logic [31:0] rdv;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; din[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      modelReset(k);
    end
    chk_en = 1'b1;

    // Reset values after the release.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("reset mem_ready dut%0d", k), {31'b0, rdy[k]}, 32'd0);
        checkOutput($sformatf("reset dout dut%0d", k), dout[k], 32'h0);
      end
    end

    // Write then read at the default latency.
    applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, rel, rabs, rdv);
    checkOutput("write latency dut0", rel, 32'd3);
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rel, rabs, rdv);
    checkOutput("read latency dut0", rel, 32'd3);
    checkOutput("read data 0x40", rdv, 32'hDEADBEEF);

    // The address wraps, and the byte offset is ignored. 0x10040 maps to the same word as 0x40.
    applyStimulus(0, 1'b0, 1'b1, 32'h0001_0040, 32'hCAFEF00D, 1'b0, rel, rabs, rdv);
    applyStimulus(0, 1'b1, 1'b0, 32'h43, 32'h0, 1'b0, rel, rabs, rdv);
    checkOutput("wrap read 0x43", rdv, 32'hCAFEF00D);

    // Changes in cycle 1 are ignored.
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, rel, rabs, rdv);
    checkOutput("midflight latency", rel, 32'd3);
    checkOutput("midflight data", rdv, 32'hCAFEF00D);

    // With both request lines high, the read wins and the word is not written.
    applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'h1, 1'b0, rel, rabs, rdv);
    checkOutput("dual read data", rdv, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rel, rabs, rdv);
    checkOutput("dual word unchanged", rdv, 32'hCAFEF00D);

    // A reset in the middle of a write discards the write.
    applyStimulus(0, 1'b0, 1'b1, 32'h80, 32'h11112222, 1'b0, rel, rabs, rdv);
    resetMidWrite(0, 32'h80, 32'h12345678);
    applyStimulus(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, rel, rabs, rdv);
    checkOutput("read after reset-write", rdv, 32'h11112222);
    resetMidWrite(2, 32'h8, 32'h55AA55AA);

    // Latency corners and back-to-back spacing for all three instances.
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, rel, rabs, rdv);
    checkOutput("latency 2", rel, 32'd1);
    applyStimulus(2, 1'b0, 1'b1, 32'h10, 32'h7777_0007, 1'b0, rel, rabs, rdv);
    checkOutput("latency 7", rel, 32'd6);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rel, rabs, rdv);
      applyStimulus(k, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rel, rabs2, rdv);
      checkOutput($sformatf("b2b spacing dut%0d", k), rabs2 - rabs, lat[k] + 1);
    end
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rel, rabs, rdv);
    checkOutput("latency 2 read data", rdv, 32'hA5A5_0001);

    // Random traffic over a small pool of words, with wrapped aliases and occasional mid-flight changes.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 25; t++) begin
        int unsigned a;
        bit          r, w;
        a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3)
            | ($urandom_range(0, 3) * dep[k] * 4);
        r = $urandom_range(0, 1);
        w = !r || ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        applyStimulus(k, r, w, a, $urandom, ($urandom_range(0, 3) == 0), rel, rabs, rdv);
        checkOutput($sformatf("random latency dut%0d", k), rel, lat[k] - 1);
      end
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
